// File: rtl/run_length_detector_mc.sv
// Per-channel detector for runs of consecutive 1s on serial bit lanes.
// Exact or at-least threshold match with saturating run counters.
module run_length_detector_mc #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      mode,
  input  logic [CNT_W-1:0]          thresh,
  input  logic                      in_valid,
  input  logic [CHANNELS-1:0]       in_data,
  output logic [CHANNELS-1:0]       hit,
  output logic [CHANNELS-1:0]       hit_pulse,
  output logic [CHANNELS*CNT_W-1:0] run_len
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    HIT,
    OVER
  } state_t;

  localparam logic [CNT_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] RUN_ONE = CNT_W'(1);

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CNT_W-1:0]    run_q   [CHANNELS];
  logic [CNT_W-1:0]    run_d   [CHANNELS];
  logic [CNT_W-1:0]    run_inc [CHANNELS];
  logic [CHANNELS-1:0] pulse_q;
  logic [CHANNELS-1:0] pulse_d;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= IDLE;
        run_q[c]   <= '0;
      end
      pulse_q <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        run_q[c]   <= run_d[c];
      end
      pulse_q <= pulse_d;
    end
  end

  // run counter saturates instead of wrapping
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      run_inc[c] = (run_q[c] == RUN_MAX) ? RUN_MAX : run_q[c] + RUN_ONE;
    end
  end

  always_comb begin
    pulse_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      run_d[c]   = run_q[c];
      if (in_valid) begin
        if (!in_data[c] || thresh == '0) begin
          state_d[c] = IDLE;
          run_d[c]   = '0;
        end else begin
          unique case (state_q[c])
            IDLE: begin
              run_d[c]   = RUN_ONE;
              state_d[c] = (thresh == RUN_ONE) ? HIT : COUNT;
            end
            COUNT: begin
              run_d[c]   = run_inc[c];
              state_d[c] = (run_inc[c] == thresh) ? HIT : COUNT;
            end
            HIT, OVER: begin
              run_d[c]   = run_inc[c];
              state_d[c] = OVER;
            end
            default: begin
              run_d[c]   = '0;
              state_d[c] = IDLE;
            end
          endcase
        end
        pulse_d[c] = (state_d[c] == HIT);
      end
    end
  end

  // mode feeds hit combinationally so it can change at any time
  always_comb begin
    hit     = '0;
    run_len = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = (state_q[c] == HIT) |
               (mode & (state_q[c] == OVER));
      run_len[c*CNT_W +: CNT_W] = run_q[c];
    end
  end

  assign hit_pulse = pulse_q;

endmodule

// File: tb/tb_run_length_detector_mc.sv
// Directed bench for run_length_detector_mc (4 channels, 3-bit counters).
// Expected outputs are queued per driven cycle and checked after the edge.
module tb_run_length_detector_mc;

  localparam int CH = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          mode;
  logic [CW-1:0] thresh;
  logic          in_valid;
  logic [CH-1:0] in_data;
  logic [CH-1:0] hit;
  logic [CH-1:0] hit_pulse;
  logic [CH*CW-1:0] run_len;

  typedef struct {
    string            tag;
    logic [CH-1:0]    hit;
    logic [CH-1:0]    pulse;
    logic [CH*CW-1:0] run;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  run_length_detector_mc #(.CHANNELS(CH), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .mode      (mode),
    .thresh    (thresh),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .hit       (hit),
    .hit_pulse (hit_pulse),
    .run_len   (run_len)
  );

  always #5 clk = ~clk;

  function automatic logic [CH*CW-1:0] rl(input int r0, r1, r2, r3);
    rl = {CW'(r3), CW'(r2), CW'(r1), CW'(r0)};
  endfunction

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL sb_empty got 0 entries exp 1");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (hit === e.hit) else begin
      failures++;
      $error("FAIL %s hit got %b exp %b", e.tag, hit, e.hit);
    end
    checks++;
    assert (hit_pulse === e.pulse) else begin
      failures++;
      $error("FAIL %s pulse got %b exp %b", e.tag, hit_pulse, e.pulse);
    end
    checks++;
    assert (run_len === e.run) else begin
      failures++;
      $error("FAIL %s run got %h exp %h", e.tag, run_len, e.run);
    end
  endtask

  // drive one cycle, queue its expected result, check after the edge
  task automatic cyc(input string tag, input logic v,
                     input logic [CH-1:0] d,
                     input logic [CH-1:0] eh,
                     input logic [CH-1:0] ep,
                     input logic [CH*CW-1:0] er);
    exp_t e;
    in_valid = v;
    in_data  = d;
    e.tag   = tag;
    e.hit   = eh;
    e.pulse = ep;
    e.run   = er;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // mode-only change: hit re-evaluates with no clock edge
  task automatic peek(input string tag, input logic [CH-1:0] eh,
                      input logic [CH-1:0] ep,
                      input logic [CH*CW-1:0] er);
    exp_t e;
    e.tag   = tag;
    e.hit   = eh;
    e.pulse = ep;
    e.run   = er;
    sb.push_back(e);
    #1;
    check_out();
  endtask

  initial begin
    rst_n    = 1'b0;
    clear    = 1'b0;
    mode     = 1'b0;
    thresh   = 3'd2;
    in_valid = 1'b0;
    in_data  = '0;
    @(negedge clk);
    cyc("reset", 1'b1, 4'hF, 4'h0, 4'h0, rl(0, 0, 0, 0));
    rst_n = 1'b1;

    // exact mode, thresh 2, ch0 1,1,1,0
    cyc("t1_b1", 1'b1, 4'h1, 4'h0, 4'h0, rl(1, 0, 0, 0));
    cyc("t1_b2", 1'b1, 4'h1, 4'h1, 4'h1, rl(2, 0, 0, 0));
    cyc("t1_b3", 1'b1, 4'h1, 4'h0, 4'h0, rl(3, 0, 0, 0));
    cyc("t1_b4", 1'b1, 4'h0, 4'h0, 4'h0, rl(0, 0, 0, 0));

    // at-least mode, same stream
    mode = 1'b1;
    cyc("t2_b1", 1'b1, 4'h1, 4'h0, 4'h0, rl(1, 0, 0, 0));
    cyc("t2_b2", 1'b1, 4'h1, 4'h1, 4'h1, rl(2, 0, 0, 0));
    cyc("t2_b3", 1'b1, 4'h1, 4'h1, 4'h0, rl(3, 0, 0, 0));
    cyc("t2_b4", 1'b1, 4'h0, 4'h0, 4'h0, rl(0, 0, 0, 0));

    // thresh 3, ch1 beats with 2-cycle gaps carrying junk data
    thresh = 3'd3;
    cyc("t3_b1", 1'b1, 4'h2, 4'h0, 4'h0, rl(0, 1, 0, 0));
    cyc("t3_g1", 1'b0, 4'hF, 4'h0, 4'h0, rl(0, 1, 0, 0));
    cyc("t3_g2", 1'b0, 4'hF, 4'h0, 4'h0, rl(0, 1, 0, 0));
    cyc("t3_b2", 1'b1, 4'h2, 4'h0, 4'h0, rl(0, 2, 0, 0));
    cyc("t3_g3", 1'b0, 4'hF, 4'h0, 4'h0, rl(0, 2, 0, 0));
    cyc("t3_g4", 1'b0, 4'hF, 4'h0, 4'h0, rl(0, 2, 0, 0));
    cyc("t3_b3", 1'b1, 4'h2, 4'h2, 4'h2, rl(0, 3, 0, 0));
    cyc("t3_hold", 1'b0, 4'h0, 4'h2, 4'h0, rl(0, 3, 0, 0));
    cyc("t3_zero", 1'b1, 4'h0, 4'h0, 4'h0, rl(0, 0, 0, 0));

    // thresh at saturation value, ch2 ten beats
    thresh = 3'd7;
    for (int i = 1; i <= 10; i++) begin
      cyc($sformatf("t4_b%0d", i), 1'b1, 4'h4,
          (i >= 7) ? 4'h4 : 4'h0,
          (i == 7) ? 4'h4 : 4'h0,
          rl(0, 0, (i > 7) ? 7 : i, 0));
    end
    mode = 1'b0;
    peek("t4_mode0", 4'h0, 4'h0, rl(0, 0, 7, 0));
    mode = 1'b1;
    peek("t4_mode1", 4'h4, 4'h0, rl(0, 0, 7, 0));
    cyc("t4_zero", 1'b1, 4'h0, 4'h0, 4'h0, rl(0, 0, 0, 0));

    // clear beats a simultaneous beat; then reset mid-run
    thresh = 3'd2;
    cyc("t5_b1", 1'b1, 4'h8, 4'h0, 4'h0, rl(0, 0, 0, 1));
    cyc("t5_b2", 1'b1, 4'h8, 4'h8, 4'h8, rl(0, 0, 0, 2));
    clear = 1'b1;
    cyc("t5_clr", 1'b1, 4'h8, 4'h0, 4'h0, rl(0, 0, 0, 0));
    clear = 1'b0;
    cyc("t5_r1", 1'b1, 4'h8, 4'h0, 4'h0, rl(0, 0, 0, 1));
    cyc("t5_r2", 1'b1, 4'h8, 4'h8, 4'h8, rl(0, 0, 0, 2));
    cyc("t5_r3", 1'b1, 4'h8, 4'h8, 4'h0, rl(0, 0, 0, 3));
    rst_n = 1'b0;
    cyc("t5_rst", 1'b1, 4'h8, 4'h0, 4'h0, rl(0, 0, 0, 0));
    rst_n = 1'b1;
    cyc("t5_after", 1'b0, 4'h8, 4'h0, 4'h0, rl(0, 0, 0, 0));

    // thresh 0 disables; thresh 1 gives a simultaneous hit on all
    thresh = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      cyc($sformatf("t6_off%0d", i), 1'b1, 4'hF, 4'h0, 4'h0,
          rl(0, 0, 0, 0));
    end
    thresh = 3'd1;
    cyc("t6_on", 1'b1, 4'hF, 4'hF, 4'hF, rl(1, 1, 1, 1));
    cyc("t6_over", 1'b1, 4'hF, 4'hF, 4'h0, rl(2, 2, 2, 2));
    thresh = 3'd5;
    cyc("t6_thold", 1'b0, 4'hF, 4'hF, 4'h0, rl(2, 2, 2, 2));
    cyc("t6_mix", 1'b1, 4'h5, 4'h5, 4'h0, rl(3, 0, 3, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
